// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, glitch rejection and frame-error/break handling.
//   clk       - system clock, all logic on rising edge
//   rst       - asynchronous active-low reset
//   rx        - asynchronous serial input, idle high
//   rx_data   - last correctly received byte, held until the next one
//   rx_valid  - one-cycle strobe: rx_data just updated
//   frame_err - one-cycle strobe: stop bit sampled low
//   busy      - receiver is anywhere but IDLE
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_m, rx_s;

    // Presetting to 1 keeps a reset release from looking like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {rx_s, rx_m} <= 2'b11;
        else      {rx_s, rx_m} <= {rx_m, rx};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (!rx_s) state <= START;
                end
                // Re-check at the middle of the start bit; a high line here was a glitch.
                START: begin
                    if (timer == T_HALF) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // Timer restarted at mid start bit, so every full period lands mid data bit.
                DATA: begin
                    if (timer == T_FULL) begin
                        timer   <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // Leaving at mid stop bit gives half a bit of slack to catch a back-to-back start edge.
                STOP: begin
                    if (timer == T_FULL) begin
                        timer <= '0;
                        if (rx_s) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // A held-low line (break) parks here so it reports only one frame error.
                WAIT_HIGH: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy;

    uart_rx #(.CLK_FREQ(160_000), .BAUD(10_000)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_both = 0;
    int valid_cyc = 0;
    int start_cyc = 0;
    logic [7:0] q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid = n_valid + 1;
            q.push_back(rx_data);
            valid_cyc = cyc;
        end
        if (frame_err) n_ferr = n_ferr + 1;
        if (rx_valid && frame_err) n_both = n_both + 1;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (16) @(negedge clk);
        end
        rx = stop;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b1;
        idle(4);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_single;
        int v0, f0, lat;
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h24, 1'b1);
        idle(20);
        lat = valid_cyc - start_cyc;
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", n_valid - v0); end
        total++; if (rx_data !== 8'h24) begin bad++; $display("FAIL single_data got=%h want=24", rx_data); end
        total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL single_ferr got=%0d want=0", n_ferr - f0); end
        total++; if (lat < 154 || lat > 156) begin bad++; $display("FAIL single_latency got=%0d want=155+/-1", lat); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [7] = '{8'h24, 8'h47, 8'h50, 8'h52, 8'h4D, 8'h43, 8'h2C};
        int v0, base;
        v0 = n_valid; base = q.size();
        for (int i = 0; i < 7; i++) send_byte(exp[i], 1'b1);
        idle(20);
        total++; if (n_valid - v0 !== 7) begin bad++; $display("FAIL b2b_count got=%0d want=7", n_valid - v0); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (base + i >= q.size()) begin
                bad++; $display("FAIL b2b_byte%0d got=none want=%h", i, exp[i]);
            end else if (q[base + i] !== exp[i]) begin
                bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, q[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=%b want=1", busy); end
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_low got=%b want=0", busy); end
        idle(20);
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", n_valid - v0); end
        total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", n_ferr - f0); end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h41, 1'b0);
        idle(32);
        total++; if (n_ferr - f0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", n_ferr - f0); end
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL ferr_valid got=%0d want=0", n_valid - v0); end
        total++; if (rx_data !== 8'h2C) begin bad++; $display("FAIL ferr_hold_data got=%h want=2c", rx_data); end
        send_byte(8'h42, 1'b1);
        idle(20);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL ferr_next_count got=%0d want=1", n_valid - v0); end
        total++; if (rx_data !== 8'h42) begin bad++; $display("FAIL ferr_next_data got=%h want=42", rx_data); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        int v0, f0;
        d = 8'h55;
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (16) @(negedge clk);
        end
        rx = d[4];
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_rx_data got=%h want=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_rx_valid got=%b want=0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL midrst_frame_err got=%b want=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        repeat (4) @(negedge clk);
        rx = 1'b1;
        rst = 1'b1;
        idle(32);
        total++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin bad++; $display("FAIL midrst_strobes got=%0d/%0d want=0/0", n_valid - v0, n_ferr - f0); end
        send_byte(8'hA5, 1'b1);
        idle(20);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL midrst_next_count got=%0d want=1", n_valid - v0); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL midrst_next_data got=%h want=a5", rx_data); end
    endtask

    task automatic test_break;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        repeat (640) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy got=%b want=1", busy); end
        total++; if (n_ferr - f0 !== 1) begin bad++; $display("FAIL break_ferr got=%0d want=1", n_ferr - f0); end
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL break_valid got=%0d want=0", n_valid - v0); end
        idle(32);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_release_busy got=%b want=0", busy); end
        send_byte(8'h0D, 1'b1);
        idle(20);
        total++; if (n_ferr - f0 !== 1) begin bad++; $display("FAIL break_ferr_after got=%0d want=1", n_ferr - f0); end
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL break_next_count got=%0d want=1", n_valid - v0); end
        total++; if (rx_data !== 8'h0D) begin bad++; $display("FAIL break_next_data got=%h want=0d", rx_data); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid;
        test_break;
        total++; if (n_both !== 0) begin bad++; $display("FAIL strobes_together got=%0d want=0", n_both); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 SHALL provide parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
- REQ-002 SHALL provide parameter BAUD, default 9600, serial bit rate in baud, matching the GPS NMEA output.
- REQ-003 SHALL define derived constant CLKS_PER_BIT = CLK_FREQ / BAUD (integer division); CLKS_PER_BIT SHALL be >= 8.
- REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge clk.
- REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
- REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line from the GPS module, idle high.
- REQ-007 SHALL have port rx_data, output, 8 bits: the last correctly received byte.
- REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle strobe marking rx_data as new; it feeds the NMEA sentence parser directly.
- REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle strobe on a stop-bit error.
- REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
- REQ-011 SHALL pass rx through a 2-flop synchronizer, preset to 1; all further logic uses the synchronized value rx_s.
- REQ-012 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH.
- REQ-013 IDLE: when rx_s == 0, SHALL go to START and clear the bit-timer.
- REQ-014 START: when the timer reaches CLKS_PER_BIT/2 - 1, SHALL resample rx_s:
  - 0 -> go to DATA, clear the timer, set bit_idx = 0.
  - 1 -> treat as a glitch and return to IDLE; no strobe.
- REQ-015 DATA: when the timer reaches CLKS_PER_BIT - 1, SHALL shift rx_s into a shift register LSB-first and clear the timer.
  - bit_idx 0..7 counts the bits.
  - After bit 7, go to STOP.
- REQ-016 STOP: when the timer reaches CLKS_PER_BIT - 1, SHALL sample rx_s:
  - 1 -> load rx_data from the shift register, pulse rx_valid, go to IDLE.
  - 0 -> pulse frame_err, leave rx_data unchanged, go to WAIT_HIGH.
- REQ-017 WAIT_HIGH: SHALL return to IDLE only when rx_s == 1; no strobes while here.
- REQ-018 rx_valid and frame_err SHALL each be high for exactly one clk cycle, registered, in the cycle after the stop-bit sample; they SHALL never be high together.
- REQ-019 rx_data SHALL hold its value until the next valid byte; no handshake and no backpressure apply, and the consumer SHALL accept the byte on the strobe cycle.
- REQ-020 Back-to-back frames SHALL be received with zero idle bits between the stop bit and the next start bit.
- REQ-021 Latency from the rx falling edge (start bit) to rx_valid SHALL be 9.5*CLKS_PER_BIT + 3 cycles, +/-1.
- REQ-022 Bit-timer width SHALL be $clog2(CLKS_PER_BIT); bit_idx width SHALL be 3 bits; no counter SHALL wrap mid-bit.
- REQ-023 The line held low (break) SHALL yield exactly one frame_err, then no further activity until rx returns high.

Reset
- REQ-024 While rst == 0, SHALL force asynchronously:
  - state = IDLE
  - timer = 0, bit_idx = 0
  - shift register = 0x00, rx_data = 0x00
  - rx_valid = 0, frame_err = 0, busy = 0
  - synchronizer flops = 1
- REQ-025 Reset asserted mid-frame SHALL abort the frame with no strobe; after release, the remainder of the aborted frame SHALL NOT produce rx_valid unless it forms a valid start bit.
- REQ-026 Deassertion of rst SHALL be synchronized externally; operation SHALL start on the first clk edge after release.

Verification (CLK_FREQ=160_000, BAUD=10_000, CLKS_PER_BIT=16)
- REQ-027 Send 0x24 ('$') with 1 stop bit -> exactly one rx_valid; rx_data = 0x24; frame_err never asserted.
- REQ-028 Send "$GPRMC," back-to-back with no idle gap -> 7 rx_valid pulses carrying 0x24, 0x47, 0x50, 0x52, 0x4D, 0x43, 0x2C, in order.
- REQ-029 Pulse rx low for 5 cycles -> no rx_valid, no frame_err; busy returns low within 10 cycles.
- REQ-030 Send 0x41 with the stop bit driven low, then line high -> one frame_err; rx_data keeps its prior value; a following 0x42 is received correctly.
- REQ-031 Assert rst during bit 4 of a 0x55 frame -> all outputs 0 immediately; after release and idle, 0xA5 -> rx_valid with rx_data = 0xA5.
- REQ-032 Hold rx low for 40 bit times -> exactly one frame_err; on rx high, a following 0x0D is received correctly.
